// File: rtl/jk_pkg.sv
// Shared encodings for the JK sequence driver: FSM states and j/k excitation codes.
package jk_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // {j,k} pairs
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// Combinational j/k excitation needed to move a JK flop from q_now_i to q_next_i.
module jk_excite
  import jk_pkg::*;
(
  input  logic       q_now_i,
  input  logic       q_next_i,
  input  logic       use_toggle_i,
  output logic [1:0] jk_o
);

  always_comb begin
    jk_o = JK_HOLD;
    if (q_now_i != q_next_i) begin
      if (use_toggle_i) jk_o = JK_TGL;
      else              jk_o = q_next_i ? JK_SET : JK_RST;
    end
  end

endmodule

// File: rtl/jk_seq_driver.sv
// Plays a WIDTH-bit target pattern into an external JK flop, LSB first, and
// counts mismatches between the fed-back q and the intended sequence.
//
// state | meaning
// IDLE  | j=k=0, pat_ready=1, waiting for a pattern
// SYNC  | one cycle, captures the flop's current q as the starting point
// DRIVE | WIDTH cycles, one bit of excitation per cycle
// DRAIN | two cycles, lets the last checks land, then pulses done
module jk_seq_driver
  import jk_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int USE_TOGGLE = 0,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pat_valid,
  input  logic [WIDTH-1:0] pat_data,
  output logic             pat_ready,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic             q_model_q, q_model_d;
  logic [1:0]       jk_q,      jk_d;
  logic [1:0]       exp_q,     exp_d;
  logic [1:0]       chk_v_q,   chk_v_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             done_q,    done_d;
  logic             match_q,   match_d;
  logic             drain_q,   drain_d;

  logic       bit_cur;
  logic [1:0] jk_exc;

  assign bit_cur = shreg_q[idx_q];

  jk_excite u_excite (
    .q_now_i      (q_model_q),
    .q_next_i     (bit_cur),
    .use_toggle_i (USE_TOGGLE != 0),
    .jk_o         (jk_exc)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    q_model_d = q_model_q;
    jk_d      = JK_HOLD;
    exp_d     = {exp_q[0], bit_cur};
    chk_v_d   = {chk_v_q[0], 1'b0};
    err_cnt_d = err_cnt_q;
    done_d    = 1'b0;
    match_d   = match_q;
    drain_d   = drain_q;

    // Stage 1 holds the bit the flop is being asked to reach; stage 2 lines it up with q_fb.
    if (chk_v_q[1] && (q_fb != exp_q[1]) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (pat_valid) begin
          shreg_d   = pat_data;
          idx_d     = '0;
          err_cnt_d = '0;
          state_d   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        q_model_d = q_fb;
        state_d   = ST_DRIVE;
      end
      ST_DRIVE: begin
        jk_d       = jk_exc;
        chk_v_d[0] = 1'b1;
        q_model_d  = bit_cur;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          drain_d = 1'b0;
          state_d = ST_DRAIN;
        end
      end
      default: begin
        if (drain_q) begin
          done_d  = 1'b1;
          match_d = (err_cnt_d == '0);
          state_d = ST_IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      q_model_q <= 1'b0;
      jk_q      <= JK_HOLD;
      exp_q     <= '0;
      chk_v_q   <= '0;
      err_cnt_q <= '0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      q_model_q <= q_model_d;
      jk_q      <= jk_d;
      exp_q     <= exp_d;
      chk_v_q   <= chk_v_d;
      err_cnt_q <= err_cnt_d;
      done_q    <= done_d;
      match_q   <= match_d;
      drain_q   <= drain_d;
    end
  end

  assign pat_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign j         = jk_q[1];
  assign k         = jk_q[0];
  assign done      = done_q;
  assign match     = match_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Drives a set-mode and a toggle-mode jk_seq_driver side by side, each with its own JK flop.
module tb_jk_seq_driver;

  localparam int WIDTH = 8;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic             rst;
  logic             pat_valid;
  logic [WIDTH-1:0] pat_data;
  logic             inject;
  logic             flop_load;
  logic [1:0]       q_flop;
  logic [1:0]       q_fb;
  logic [1:0]       pat_ready_w, j_w, k_w, busy_w, done_w, match_w;
  logic [CNT_W-1:0] err_w [2];

  int n_vec = 0;
  int n_err = 0;

  assign q_fb[0] = inject ? 1'b0 : q_flop[0];
  assign q_fb[1] = inject ? 1'b0 : q_flop[1];

  jk_seq_driver #(.WIDTH(WIDTH), .USE_TOGGLE(0), .CNT_W(CNT_W)) u_set (
    .clk(clk), .rst(rst), .pat_valid(pat_valid), .pat_data(pat_data),
    .pat_ready(pat_ready_w[0]), .j(j_w[0]), .k(k_w[0]), .q_fb(q_fb[0]),
    .busy(busy_w[0]), .done(done_w[0]), .match(match_w[0]), .err_cnt(err_w[0])
  );

  jk_seq_driver #(.WIDTH(WIDTH), .USE_TOGGLE(1), .CNT_W(CNT_W)) u_tgl (
    .clk(clk), .rst(rst), .pat_valid(pat_valid), .pat_data(pat_data),
    .pat_ready(pat_ready_w[1]), .j(j_w[1]), .k(k_w[1]), .q_fb(q_fb[1]),
    .busy(busy_w[1]), .done(done_w[1]), .match(match_w[1]), .err_cnt(err_w[1])
  );

  // Behavioural JK flops; flop_load presets set-mode flop to 0 and toggle-mode flop to 1.
  always @(posedge clk) begin
    if (flop_load) q_flop <= 2'b10;
    else begin
      for (int m = 0; m < 2; m++) begin
        case ({j_w[m], k_w[m]})
          2'b10:   q_flop[m] <= 1'b1;
          2'b01:   q_flop[m] <= 1'b0;
          2'b11:   q_flop[m] <= ~q_flop[m];
          default: q_flop[m] <= q_flop[m];
        endcase
      end
    end
  end

  logic       ex_q, ex_n, ex_t;
  logic [1:0] ex_jk;
  jk_excite u_exc (.q_now_i(ex_q), .q_next_i(ex_n), .use_toggle_i(ex_t), .jk_o(ex_jk));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Excitation the flop needs to go from prev to b.
  function automatic logic [1:0] want_jk(input logic prev, input logic b, input bit tgl);
    if (prev == b) return 2'b00;
    if (tgl)       return 2'b11;
    return b ? 2'b10 : 2'b01;
  endfunction

  task automatic idle_cycles(input int n);
    logic [1:0]       q_save;
    logic [CNT_W-1:0] e_save [2];
    q_save = q_flop;
    e_save[0] = err_w[0];
    e_save[1] = err_w[1];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("idle u%0d jk", m), 32'({j_w[m], k_w[m]}), 32'd0);
        chk($sformatf("idle u%0d busy", m), 32'(busy_w[m]), 32'd0);
        chk($sformatf("idle u%0d ready", m), 32'(pat_ready_w[m]), 32'd1);
        chk($sformatf("idle u%0d done", m), 32'(done_w[m]), 32'd0);
        chk($sformatf("idle u%0d q", m), 32'(q_flop[m]), 32'(q_save[m]));
        chk($sformatf("idle u%0d err", m), 32'(err_w[m]), 32'(e_save[m]));
      end
    end
  endtask

  // Called just after a negedge. With hold=1, pat_valid stays high throughout and
  // next_data is presented in the done cycle for a back-to-back handshake.
  task automatic run_pattern(input logic [WIDTH-1:0] data, input bit inj,
                             input bit hold, input logic [WIDTH-1:0] next_data);
    logic [1:0] jke [2][WIDTH];
    logic       prev;
    int         exp_err;
    pat_valid = 1'b1;
    pat_data  = data;
    inject    = inj;
    for (int m = 0; m < 2; m++) begin
      prev = inj ? 1'b0 : q_flop[m];
      for (int i = 0; i < WIDTH; i++) begin
        jke[m][i] = want_jk(prev, data[i], m == 1);
        prev = data[i];
      end
    end
    exp_err = inj ? $countones(data) : 0;
    @(posedge clk);
    for (int c = 0; c <= WIDTH + 3; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) pat_valid = 1'b0;
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("u%0d c%0d busy", m, c), 32'(busy_w[m]), 32'(c < WIDTH + 3));
        chk($sformatf("u%0d c%0d ready", m, c), 32'(pat_ready_w[m]), 32'(c == WIDTH + 3));
        chk($sformatf("u%0d c%0d done", m, c), 32'(done_w[m]), 32'(c == WIDTH + 3));
        chk($sformatf("u%0d c%0d jk", m, c), 32'({j_w[m], k_w[m]}),
            (c >= 2 && c <= WIDTH + 1) ? 32'(jke[m][c-2]) : 32'd0);
        if (!inj && c >= 3 && c <= WIDTH + 2)
          chk($sformatf("u%0d c%0d q", m, c), 32'(q_flop[m]), 32'(data[c-3]));
        if (c == 0)
          chk($sformatf("u%0d clr err", m), 32'(err_w[m]), 32'd0);
        if (c == WIDTH + 3) begin
          chk($sformatf("u%0d err_cnt", m), 32'(err_w[m]), 32'(exp_err));
          chk($sformatf("u%0d match", m), 32'(match_w[m]), 32'(exp_err == 0));
        end
      end
      if (hold && c < WIDTH + 3) pat_data = WIDTH'($urandom);
    end
    inject = 1'b0;
    if (hold) pat_data = next_data;
  endtask

  initial begin
    #1_000_000;
    $display("timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] cur, nxt;
    bit               inj, hold;

    for (int v = 0; v < 8; v++) begin
      {ex_t, ex_q, ex_n} = 3'(v);
      #1;
      chk($sformatf("excite %0d", v), 32'(ex_jk), 32'(want_jk(ex_q, ex_n, ex_t)));
    end

    rst = 1'b1; pat_valid = 1'b0; pat_data = '0; inject = 1'b0; flop_load = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; flop_load = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst u%0d ready", m), 32'(pat_ready_w[m]), 32'd1);
      chk($sformatf("rst u%0d jk", m), 32'({j_w[m], k_w[m]}), 32'd0);
      chk($sformatf("rst u%0d busy", m), 32'(busy_w[m]), 32'd0);
      chk($sformatf("rst u%0d done", m), 32'(done_w[m]), 32'd0);
      chk($sformatf("rst u%0d match", m), 32'(match_w[m]), 32'd0);
      chk($sformatf("rst u%0d err", m), 32'(err_w[m]), 32'd0);
    end
    idle_cycles(2);

    run_pattern(8'b1011_0010, 1'b0, 1'b0, '0);
    idle_cycles(1);
    run_pattern(8'h55, 1'b0, 1'b0, '0);
    idle_cycles(1);
    run_pattern(8'hFF, 1'b1, 1'b0, '0);
    idle_cycles(2);

    // Errors in the first pattern must be wiped by the back-to-back handshake.
    run_pattern(WIDTH'($urandom) | 8'h81, 1'b1, 1'b1, 8'h00);
    run_pattern(8'h00, 1'b0, 1'b0, '0);
    idle_cycles(1);

    pat_valid = 1'b1; pat_data = 8'hFF; inject = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pat_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int m = 0; m < 2; m++)
      chk($sformatf("pre-rst u%0d err", m), 32'(err_w[m]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; inject = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("midrst u%0d busy", m), 32'(busy_w[m]), 32'd0);
      chk($sformatf("midrst u%0d ready", m), 32'(pat_ready_w[m]), 32'd1);
      chk($sformatf("midrst u%0d jk", m), 32'({j_w[m], k_w[m]}), 32'd0);
      chk($sformatf("midrst u%0d err", m), 32'(err_w[m]), 32'd0);
      chk($sformatf("midrst u%0d done", m), 32'(done_w[m]), 32'd0);
    end
    idle_cycles(4);

    cur = WIDTH'($urandom);
    for (int t = 0; t < 16; t++) begin
      nxt  = WIDTH'($urandom);
      inj  = ($urandom_range(0, 3) == 0);
      hold = (t < 15) && ($urandom_range(0, 3) == 0);
      run_pattern(cur, inj, hold, nxt);
      if (!hold) idle_cycles(int'($urandom_range(0, 2)));
      cur = nxt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
